// File: rtl/booth_seq_multiplier_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_seq_multiplier_pkg                                     |
// | Description : Shared types and helpers for the iterative radix-2^R Booth   |
// |               multiplier: FSM state enum, Booth digit struct and the       |
// |               digit-count helper.                                          |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package booth_seq_multiplier_pkg;

  // Widest supported radix (radix-16). Digit magnitudes reach 2^(R-1), which
  // always fits in MAX_RADIX_LOG2 bits; narrower radices leave upper bits zero.
  localparam int MAX_RADIX_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECOMP = 2'd1,
    ITER    = 2'd2,
    DONE    = 2'd3
  } mul_state_t;

  typedef struct packed {
    logic [MAX_RADIX_LOG2-1:0] mag;
    logic                      neg;
  } booth_digit_t;

  // N = ceil((width + 1) / r): digits needed to cover the extended multiplier.
  function automatic int booth_num_digits(input int width, input int r);
    return (width + r) / r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_seq_multiplier_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_seq_multiplier_if                                      |
// | Description : Operand and result valid/ready handshake bundle.             |
// | Ports       : in_valid/in_ready/signed_mode/multiplicand/multiplier        |
// |               (operand side), out_valid/out_ready/product (result side).   |
// |               master = requester, slave = multiplier.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, signed_mode, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product
  );
endinterface
`default_nettype wire

// File: rtl/booth_seq_multiplier_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_digit_encoder                                          |
// | Description : Combinational radix-2^R Booth digit encoder. Maps an (R+1)-  |
// |               bit window {b[R*i+R-1:R*i], b[R*i-1]} to sign + magnitude.   |
// | Ports       : window (in, R+1)  - multiplier window, LSB is the overlap bit |
// |               digit  (out)      - booth_digit_t {mag, neg}                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module booth_digit_encoder
  import booth_seq_multiplier_pkg::*;
#(
  parameter int RADIX_LOG2 = 4
) (
  input  logic [RADIX_LOG2:0] window,
  output booth_digit_t        digit
);

  localparam logic [MAX_RADIX_LOG2-1:0] HALF = MAX_RADIX_LOG2'(1 << (RADIX_LOG2 - 1));

  // pos = sum of the non-sign window terms; value d = pos - neg*2^(R-1).
  // For negative digits the magnitude is 2^(R-1) - pos, so an all-ones window
  // yields mag = 0 and contributes nothing regardless of neg.
  logic [MAX_RADIX_LOG2-1:0] pos;

  always_comb begin
    pos = MAX_RADIX_LOG2'(window[0]);
    for (int j = 1; j < RADIX_LOG2; j++) begin
      pos = pos + (MAX_RADIX_LOG2'(window[j]) << (j - 1));
    end
    digit.neg = window[RADIX_LOG2];
    digit.mag = window[RADIX_LOG2] ? (HALF - pos) : pos;
  end

endmodule
`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : booth_seq_multiplier                                         |
// | Description : Iterative radix-2^R Booth multiplier, one digit per clock.   |
// |               IDLE -> PRECOMP (odd multiples) -> ITER x N -> DONE.          |
// | Ports       : clk   (in)  rising-edge clock                                |
// |               rst_n (in)  asynchronous active-low reset                    |
// |               bus   (slave modport) operand/result handshakes, product     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int RADIX_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_seq_multiplier_if.slave bus
);

  localparam int N_DIGITS = booth_num_digits(WIDTH, RADIX_LOG2);
  localparam int B_BITS   = N_DIGITS * RADIX_LOG2;
  localparam int EXT_W    = WIDTH + 1;
  localparam int MULT_W   = EXT_W + RADIX_LOG2;             // holds up to 2^(R-1)*|A|
  localparam int ACC_W    = B_BITS + WIDTH + RADIX_LOG2 + 2;
  localparam int CNT_W    = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

  mul_state_t                 state;
  logic [EXT_W-1:0]           a_ext;
  logic [B_BITS:0]            b_sr;       // extended B plus the B[-1] overlap bit
  logic [ACC_W-1:0]           acc;
  logic [CNT_W-1:0]           digit_cnt;
  logic [2*WIDTH-1:0]         product_r;
  logic                       out_valid_r;

  logic [EXT_W-1:0]           a_in_ext;
  logic [EXT_W-1:0]           b_in_ext;
  logic [MULT_W-1:0]          a_mult;
  logic [MULT_W-1:0]          mult3;
  logic [MULT_W-1:0]          mult5;
  logic [MULT_W-1:0]          mult7;
  logic [MULT_W-1:0]          sel_mult;
  logic [MULT_W:0]            sel_ext;
  logic [MULT_W:0]            addend;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    acc_next;
  booth_digit_t               digit;

  assign a_in_ext = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
  assign b_in_ext = {bus.signed_mode & bus.multiplier[WIDTH-1],   bus.multiplier};
  assign a_mult   = MULT_W'($signed(a_ext));

  booth_digit_encoder #(
    .RADIX_LOG2 (RADIX_LOG2)
  ) u_encoder (
    .window (b_sr[RADIX_LOG2:0]),
    .digit  (digit)
  );

  // Odd multiples exist only for the radices that need them.
  if (RADIX_LOG2 >= 3) begin : g_mult3
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 mult3 <= '0;
      else if (state == PRECOMP)  mult3 <= a_mult + (a_mult << 1);
    end
  end else begin : g_no_mult3
    assign mult3 = '0;
  end

  if (RADIX_LOG2 == 4) begin : g_mult57
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mult5 <= '0;
        mult7 <= '0;
      end else if (state == PRECOMP) begin
        mult5 <= a_mult + (a_mult << 2);
        mult7 <= (a_mult << 3) - a_mult;
      end
    end
  end else begin : g_no_mult57
    assign mult5 = '0;
    assign mult7 = '0;
  end

  always_comb begin
    sel_mult = '0;
    case (digit.mag)
      4'd1:    sel_mult = a_mult;
      4'd2:    sel_mult = a_mult << 1;
      4'd3:    sel_mult = mult3;
      4'd4:    sel_mult = a_mult << 2;
      4'd5:    sel_mult = mult5;
      4'd6:    sel_mult = mult3 << 1;
      4'd7:    sel_mult = mult7;
      4'd8:    sel_mult = a_mult << 3;
      default: sel_mult = '0;
    endcase
  end

  // The digit's partial product is added B_BITS above the LSB; after N
  // add-and-shift steps every digit lands at weight 2^(R*i) exactly.
  assign sel_ext  = {sel_mult[MULT_W-1], sel_mult};
  assign addend   = digit.neg ? -sel_ext : sel_ext;
  assign acc_sum  = acc + {addend, {B_BITS{1'b0}}};
  assign acc_next = acc_sum >>> RADIX_LOG2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_ext       <= '0;
      b_sr        <= '0;
      acc         <= '0;
      digit_cnt   <= '0;
      product_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_ext     <= a_in_ext;
            b_sr      <= {B_BITS'($signed(b_in_ext)), 1'b0};
            acc       <= '0;
            digit_cnt <= '0;
            state     <= PRECOMP;
          end
        end
        PRECOMP: state <= ITER;
        ITER: begin
          acc  <= acc_next;
          b_sr <= $signed(b_sr) >>> RADIX_LOG2;
          if (digit_cnt == LAST_DIGIT) begin
            product_r   <= acc_next[2*WIDTH-1:0];
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            digit_cnt <= digit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_booth_seq_multiplier                                      |
// | Description : Self-checking bench. Main DUT is WIDTH=16/R=4; three more    |
// |               instances (8/R1, 16/R2, 32/R3) run a lockstep random sweep.  |
// |               Expected products come from plain integer multiplication.    |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_booth_seq_multiplier;

  localparam int LAT_LIMIT   = 64;
  localparam int MAIN_OPS    = 300;
  localparam int OTHER_OPS   = 200;
  localparam int BP_LIMIT    = 6;
  localparam int MAIN_LAT    = 7;   // WIDTH=16, R=4: N=5, latency N+2

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier_if #(.WIDTH(16)) m_bus ();

  booth_seq_multiplier #(
    .WIDTH      (16),
    .RADIX_LOG2 (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_bus)
  );

  // Side instances for the other radices, driven through flat arrays so one
  // task can step them all with a run-time index.
  logic        x_in_valid [3];
  logic        x_in_ready [3];
  logic        x_sm       [3];
  logic [63:0] x_a        [3];
  logic [63:0] x_b        [3];
  logic        x_ready    [3];
  logic        x_valid    [3];
  logic [63:0] x_prod     [3];

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int CW = (g == 0) ? 8 : ((g == 1) ? 16 : 32);
    localparam int CR = g + 1;
    booth_seq_multiplier_if #(.WIDTH(CW)) cfg_bus ();
    booth_seq_multiplier #(
      .WIDTH      (CW),
      .RADIX_LOG2 (CR)
    ) cfg_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (cfg_bus)
    );
    assign cfg_bus.in_valid     = x_in_valid[g];
    assign cfg_bus.signed_mode  = x_sm[g];
    assign cfg_bus.multiplicand = x_a[g][CW-1:0];
    assign cfg_bus.multiplier   = x_b[g][CW-1:0];
    assign cfg_bus.out_ready    = x_ready[g];
    assign x_in_ready[g]        = cfg_bus.in_ready;
    assign x_valid[g]           = cfg_bus.out_valid;
    assign x_prod[g]            = 64'(cfg_bus.product);
  end

  function automatic int cfg_width(input int c);
    return (c == 0) ? 8 : ((c == 1) ? 16 : 32);
  endfunction

  function automatic int cfg_digits(input int c);
    int w;
    int r;
    w = cfg_width(c);
    r = c + 1;
    return (w + 1 + r - 1) / r;
  endfunction

  // Exact product of w-bit operands, low 2w bits.
  function automatic logic [63:0] ref_mul(input bit sm, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'(a);
    sb = longint'(b);
    if (sm) begin
      sa = (sa <<< (64 - w)) >>> (64 - w);
      sb = (sb <<< (64 - w)) >>> (64 - w);
    end
    p = 64'(sa * sb);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  function automatic logic [31:0] ref16(input bit sm, input logic [15:0] a, input logic [15:0] b);
    return 32'(ref_mul(sm, {48'd0, a}, {48'd0, b}, 16));
  endfunction

  // Drives one main-DUT operation. lat counts the handshake edge as 1 and
  // stops at the first sample where out_valid is high (LAT_LIMIT on timeout).
  task automatic run_op(input bit sm, input logic [15:0] a, input logic [15:0] b,
                        input int hold, output logic [31:0] prod, output int lat);
    @(negedge clk);
    m_bus.signed_mode  = sm;
    m_bus.multiplicand = a;
    m_bus.multiplier   = b;
    m_bus.in_valid     = 1'b1;
    m_bus.out_ready    = 1'b0;
    @(posedge clk);
    #1;
    m_bus.in_valid     = 1'b0;
    m_bus.multiplicand = 16'($urandom);
    m_bus.multiplier   = 16'($urandom);
    m_bus.signed_mode  = 1'($urandom_range(0, 1));
    lat = 1;
    while (m_bus.out_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = m_bus.product;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    m_bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (m_bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b expected 1", m_bus.in_ready);
    end
    tests++;
    if (m_bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b expected 0", m_bus.out_valid);
    end
    tests++;
    if (m_bus.product !== 32'h0) begin
      fails++; $display("FAIL reset_product: got %h expected 00000000", m_bus.product);
    end
  endtask

  task automatic test_signed_extreme();
    logic [31:0] p;
    int          lat;
    run_op(1'b1, 16'h8000, 16'h8000, 0, p, lat);
    tests++;
    if (p !== 32'h4000_0000) begin
      fails++; $display("FAIL signed_extreme: got %h expected 40000000", p);
    end
    tests++;
    if (lat !== MAIN_LAT) begin
      fails++; $display("FAIL signed_extreme_latency: got %0d expected %0d", lat, MAIN_LAT);
    end
  endtask

  task automatic test_unsigned_max();
    logic [31:0] p;
    int          lat;
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1, p, lat);
    tests++;
    if (p !== 32'hFFFE_0001) begin
      fails++; $display("FAIL unsigned_max: got %h expected fffe0001", p);
    end
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 0, p, lat);
    tests++;
    if (p !== 32'h0000_0001) begin
      fails++; $display("FAIL signed_minus_one_sq: got %h expected 00000001", p);
    end
  endtask

  task automatic test_mode();
    logic [31:0] p;
    int          lat;
    run_op(1'b1, 16'h0003, 16'hFFFF, 0, p, lat);
    tests++;
    if (p !== 32'hFFFF_FFFD) begin
      fails++; $display("FAIL mode_signed: got %h expected fffffffd", p);
    end
    run_op(1'b0, 16'h0003, 16'hFFFF, 0, p, lat);
    tests++;
    if (p !== 32'h0002_FFFD) begin
      fails++; $display("FAIL mode_unsigned: got %h expected 0002fffd", p);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic [31:0] exp_p;
    logic [31:0] p;
    int          lat;
    exp_p = ref16(1'b0, 16'h7123, 16'h00F1);
    @(negedge clk);
    m_bus.signed_mode  = 1'b0;
    m_bus.multiplicand = 16'h7123;
    m_bus.multiplier   = 16'h00F1;
    m_bus.in_valid     = 1'b1;
    m_bus.out_ready    = 1'b0;
    @(posedge clk);
    #1;
    m_bus.in_valid = 1'b0;
    lat = 1;
    while (m_bus.out_valid !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    held = m_bus.product;
    tests++;
    if (held !== exp_p) begin
      fails++; $display("FAIL bp_product: got %h expected %h", held, exp_p);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m_bus.in_valid     = (c % 2 == 0);
      m_bus.multiplicand = 16'($urandom);
      m_bus.multiplier   = 16'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if (m_bus.product !== exp_p || m_bus.out_valid !== 1'b1 || m_bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: got product=%h out_valid=%b in_ready=%b expected product=%h out_valid=1 in_ready=0",
                 c, m_bus.product, m_bus.out_valid, m_bus.in_ready, exp_p);
      end
    end
    @(negedge clk);
    m_bus.in_valid  = 1'b0;
    m_bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_bus.out_ready = 1'b0;
    tests++;
    if (m_bus.out_valid !== 1'b0 || m_bus.in_ready !== 1'b1 || m_bus.product !== exp_p) begin
      fails++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b product=%h expected out_valid=0 in_ready=1 product=%h",
               m_bus.out_valid, m_bus.in_ready, m_bus.product, exp_p);
    end
    run_op(1'b0, 16'h00AB, 16'h0102, 0, p, lat);
    tests++;
    if (p !== ref16(1'b0, 16'h00AB, 16'h0102) || lat !== MAIN_LAT) begin
      fails++;
      $display("FAIL bp_next_op: got %h lat %0d expected %h lat %0d",
               p, lat, ref16(1'b0, 16'h00AB, 16'h0102), MAIN_LAT);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] p;
    int          lat;
    @(negedge clk);
    m_bus.signed_mode  = 1'b1;
    m_bus.multiplicand = 16'h5A5A;
    m_bus.multiplier   = 16'h3C3C;
    m_bus.in_valid     = 1'b1;
    @(posedge clk);                 // handshake
    #1;
    m_bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);      // PRECOMP, ITER 1, ITER 2 complete
    #2;
    rst_n = 1'b0;                   // inside the third ITER cycle
    #1;
    tests++;
    if (m_bus.out_valid !== 1'b0 || m_bus.product !== 32'h0 || m_bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: got out_valid=%b product=%h in_ready=%b expected 0/00000000/1",
               m_bus.out_valid, m_bus.product, m_bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if (m_bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL mid_reset_no_result cycle %0d: got %b expected 0", c, m_bus.out_valid);
      end
    end
    run_op(1'b1, 16'h1234, 16'h0056, 0, p, lat);
    tests++;
    if (p !== ref16(1'b1, 16'h1234, 16'h0056) || lat !== MAIN_LAT) begin
      fails++;
      $display("FAIL mid_reset_clean_op: got %h lat %0d expected %h lat %0d",
               p, lat, ref16(1'b1, 16'h1234, 16'h0056), MAIN_LAT);
    end
  endtask

  task automatic test_random_sweep();
    logic [31:0] p;
    logic [31:0] e;
    logic [15:0] a;
    logic [15:0] b;
    bit          sm;
    int          lat;
    for (int op = 0; op < MAIN_OPS; op++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      e  = ref16(sm, a, b);
      run_op(sm, a, b, $urandom_range(0, 3), p, lat);
      tests++;
      if (p !== e || lat !== MAIN_LAT) begin
        fails++;
        $display("FAIL random16 op %0d (sm=%0d a=%h b=%h): got %h lat %0d expected %h lat %0d",
                 op, sm, a, b, p, lat, e, MAIN_LAT);
      end
    end
  endtask

  task automatic test_other_radices();
    logic [63:0] exp_p [3];
    logic [63:0] mask;
    int          lat   [3];
    bit          seen  [3];
    bit          taken [3];
    int          cyc;
    for (int op = 0; op < OTHER_OPS; op++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        mask          = (64'd1 << cfg_width(c)) - 64'd1;
        x_sm[c]       = 1'($urandom_range(0, 1));
        x_a[c]        = {$urandom(), $urandom()} & mask;
        x_b[c]        = {$urandom(), $urandom()} & mask;
        exp_p[c]      = ref_mul(x_sm[c], x_a[c], x_b[c], cfg_width(c));
        x_in_valid[c] = 1'b1;
        x_ready[c]    = 1'b0;
        seen[c]       = 1'b0;
        taken[c]      = 1'b0;
        lat[c]        = 0;
        tests++;
        if (x_in_ready[c] !== 1'b1) begin
          fails++; $display("FAIL other_in_ready cfg%0d op %0d: got %b expected 1", c, op, x_in_ready[c]);
        end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) x_in_valid[c] = 1'b0;
      cyc = 1;
      forever begin
        for (int c = 0; c < 3; c++) begin
          if (!seen[c] && x_valid[c] === 1'b1) begin
            seen[c] = 1'b1;
            lat[c]  = cyc;
          end
        end
        if ((seen[0] && seen[1] && seen[2]) || cyc >= LAT_LIMIT) break;
        @(posedge clk);
        #1;
        cyc++;
      end
      for (int c = 0; c < 3; c++) begin
        tests++;
        if (lat[c] !== cfg_digits(c) + 2 || x_prod[c] !== exp_p[c]) begin
          fails++;
          $display("FAIL other cfg%0d op %0d (sm=%0d a=%h b=%h): got %h lat %0d expected %h lat %0d",
                   c, op, x_sm[c], x_a[c], x_b[c], x_prod[c], lat[c], exp_p[c], cfg_digits(c) + 2);
        end
      end
      for (int k = 0; k < BP_LIMIT && !(taken[0] && taken[1] && taken[2]); k++) begin
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
          if (!taken[c]) x_ready[c] = (k == BP_LIMIT - 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
          if (!taken[c]) begin
            tests++;
            if (x_ready[c]) begin
              taken[c] = 1'b1;
              if (x_valid[c] !== 1'b0) begin
                fails++; $display("FAIL other_release cfg%0d op %0d: got out_valid=%b expected 0", c, op, x_valid[c]);
              end
            end else if (x_valid[c] !== 1'b1 || x_prod[c] !== exp_p[c]) begin
              fails++;
              $display("FAIL other_hold cfg%0d op %0d: got valid=%b product=%h expected valid=1 product=%h",
                       c, op, x_valid[c], x_prod[c], exp_p[c]);
            end
          end
        end
      end
      @(negedge clk);
      for (int c = 0; c < 3; c++) x_ready[c] = 1'b0;
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    m_bus.in_valid     = 1'b0;
    m_bus.signed_mode  = 1'b0;
    m_bus.multiplicand = '0;
    m_bus.multiplier   = '0;
    m_bus.out_ready    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      x_in_valid[c] = 1'b0;
      x_sm[c]       = 1'b0;
      x_a[c]        = '0;
      x_b[c]        = '0;
      x_ready[c]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_signed_extreme();
    test_unsigned_max();
    test_mode();
    test_backpressure();
    test_reset_mid_op();
    test_random_sweep();
    test_other_radices();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
